// File: rtl/ins_sequencer_pkg.sv
// Shared types for the instruction fetch/issue controller: stepping modes,
// per-cycle action selection and the default NOP encoding.
package ins_seq_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_RUN    = 2'd1,
        MODE_HALTED = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_RESTART,
        ACT_CUR_LEFT,
        ACT_CUR_RIGHT,
        ACT_MAN,
        ACT_BRANCH,
        ACT_ROM
    } action_t;

    // NOP for the default 16-bit instruction width: only the MSB set.
    localparam logic [15:0] NOP_INS = 16'h8000;

endpackage

// File: rtl/ins_sequencer_run_divider.sv
// Free-running issue-slot divider for RUN mode: pulses o_tc once every DIV
// enabled cycles; i_clr forces the count back to zero.
module run_divider #(
    parameter int unsigned DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == DW'(DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + DW'(1);
        end
    end

endmodule

// File: rtl/ins_sequencer.sv
// Instruction fetch/issue controller: owns the PC, memory cursor and stepping
// mode, and issues ROM or switch instructions to the controller one per slot.
module ins_sequencer
    import ins_seq_pkg::*;
#(
    parameter int unsigned INS_W   = 16,
    parameter int unsigned PC_W    = 5,
    parameter int unsigned CUR_W   = 4,
    parameter int unsigned RUN_DIV = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             restart,
    input  logic             step,
    input  logic             run_toggle,
    input  logic             cur_left,
    input  logic             cur_right,
    input  logic             man_valid,
    input  logic [INS_W-1:0] man_ins,
    input  logic [INS_W-1:0] rom_ins,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pc,
    output logic [INS_W-1:0] issue_ins,
    output logic             issue_valid,
    output logic             issue_from_rom,
    output logic [CUR_W-1:0] cursor,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam logic [INS_W-1:0] NOP = {1'b1, {(INS_W-1){1'b0}}};

    mode_t            r_mode,  w_mode;
    logic [PC_W-1:0]  r_pc,    w_pc;
    logic [CUR_W-1:0] r_cursor, w_cursor;
    logic [INS_W-1:0] r_ins,   w_ins;
    logic             r_valid, w_valid;
    logic             r_from_rom, w_from_rom;
    logic [CNT_W-1:0] r_cnt,   w_cnt;

    action_t w_action;
    logic    w_tc, w_div_en, w_div_clr;
    logic    w_halt, w_branch, w_rom_go, w_man_ok;

    assign w_div_en  = (r_mode == MODE_RUN);
    assign w_div_clr = restart || (run_toggle && r_mode == MODE_IDLE);

    run_divider #(.DIV(RUN_DIV)) u_run_divider (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_en    (w_div_en),
        .i_clr   (w_div_clr),
        .o_tc    (w_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode     <= MODE_IDLE;
            r_pc       <= '0;
            r_cursor   <= '0;
            r_ins      <= NOP;
            r_valid    <= 1'b0;
            r_from_rom <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_mode     <= w_mode;
            r_pc       <= w_pc;
            r_cursor   <= w_cursor;
            r_ins      <= w_ins;
            r_valid    <= w_valid;
            r_from_rom <= w_from_rom;
            r_cnt      <= w_cnt;
        end
    end

    always_comb begin
        w_halt   = r_valid && halt_req;
        w_branch = r_valid && r_from_rom && branch_taken;
        w_man_ok = man_valid && (r_mode != MODE_HALTED);
        // A halting instruction must not be followed by a ROM issue in the same cycle.
        w_rom_go = !w_halt && ((r_mode == MODE_IDLE && step) || w_tc);

        if (restart)        w_action = ACT_RESTART;
        else if (cur_left)  w_action = ACT_CUR_LEFT;
        else if (cur_right) w_action = ACT_CUR_RIGHT;
        else if (w_man_ok)  w_action = ACT_MAN;
        else if (w_branch)  w_action = ACT_BRANCH;
        else if (w_rom_go)  w_action = ACT_ROM;
        else                w_action = ACT_NONE;

        w_pc       = r_pc;
        w_cursor   = r_cursor;
        w_ins      = NOP;
        w_valid    = 1'b0;
        w_from_rom = 1'b0;
        w_cnt      = r_cnt;

        case (w_action)
            ACT_RESTART: begin
                w_pc  = '0;
                w_cnt = '0;
            end
            ACT_CUR_LEFT:  w_cursor = r_cursor - CUR_W'(1);
            ACT_CUR_RIGHT: w_cursor = r_cursor + CUR_W'(1);
            ACT_MAN: begin
                w_ins   = man_ins;
                w_valid = 1'b1;
            end
            ACT_BRANCH: w_pc = branch_target;
            ACT_ROM: begin
                w_ins      = rom_ins;
                w_valid    = 1'b1;
                w_from_rom = 1'b1;
                w_pc       = r_pc + PC_W'(1);
            end
            default: ;
        endcase

        if (w_valid && r_cnt != '1) w_cnt = r_cnt + CNT_W'(1);

        w_mode = r_mode;
        if (restart)                                 w_mode = MODE_IDLE;
        else if (w_halt)                             w_mode = MODE_HALTED;
        else if (run_toggle && r_mode == MODE_IDLE)  w_mode = MODE_RUN;
        else if (run_toggle && r_mode == MODE_RUN)   w_mode = MODE_IDLE;
    end

    assign pc             = r_pc;
    assign issue_ins      = r_ins;
    assign issue_valid    = r_valid;
    assign issue_from_rom = r_from_rom;
    assign cursor         = r_cursor;
    assign mode           = r_mode;
    assign issue_cnt      = r_cnt;

endmodule
